// File: rtl/bus_pkg.sv
// Shared definitions for the bus master port: FSM state encodings and sizing helpers.
package bus_pkg;

    // FSM state encodings
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReq   = 3'd1;
    localparam logic [2:0] StXfer  = 3'd2;
    localparam logic [2:0] StFlush = 3'd3;
    localparam logic [2:0] StGap   = 3'd4;

    // Number of req-low cycles inserted after every burst
    localparam int unsigned GapCycles = 1;

    // Width of the grant-timeout counter; at least one bit even when the timeout is disabled
    function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/bus_cmd_fifo.sv
// Synchronous command FIFO with occupancy count, full and empty flags. Depth is a power of two.
module bus_cmd_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic [$clog2(Depth):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam logic [PtrWidth:0]   DepthCnt = Depth[PtrWidth:0];
    localparam logic [PtrWidth:0]   CntOne   = 1;
    localparam logic [PtrWidth-1:0] PtrOne   = 1;

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrWidth:0]   count_q, count_d;
    logic                push_ok, pop_ok;

    assign full_o  = (count_q == DepthCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PtrOne : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntOne;
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CntOne;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; no reset needed since entries are only read when valid
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bus_master_port.sv
// Master-side endpoint of the shared req/grant bus: queues burst commands, requests the bus,
// streams write beats while granted, and flushes commands whose grant never arrives.
module bus_master_port
    import bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned LEN_WIDTH     = 3,
    parameter int unsigned GRANT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  req,
    input  logic                  grant,
    output logic                  bus_valid,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data,
    output logic                  bus_last,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  err_clr
);
    localparam int unsigned CmdWidth   = ADDR_WIDTH + LEN_WIDTH;
    localparam int unsigned CntWidth   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TmoWidth   = tmo_cnt_width(GRANT_TIMEOUT);
    localparam int unsigned TmoLastInt = (GRANT_TIMEOUT == 0) ? 0 : GRANT_TIMEOUT - 1;
    localparam logic [TmoWidth-1:0]  TmoLast  = TmoLastInt[TmoWidth-1:0];
    localparam logic [TmoWidth-1:0]  TmoOne   = 1;
    localparam logic [LEN_WIDTH-1:0] BeatOne  = 1;
    localparam logic [CntWidth-1:0]  DepthCnt = FIFO_DEPTH[CntWidth-1:0];
    localparam bit                   TimeoutEn = (GRANT_TIMEOUT != 0);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
    } cmd_t;

    logic [2:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] beat_q, beat_d;
    logic [TmoWidth-1:0]  tmo_q, tmo_d;
    logic                 err_q, err_d;
    logic                 tmo_set;

    logic                 push, pop;
    logic [CmdWidth-1:0]  fifo_rdata;
    logic [CntWidth-1:0]  fifo_count;
    logic                 fifo_full, fifo_empty;
    cmd_t                 head;
    logic                 beat_fire, flush_fire, is_last;

    assign head      = fifo_rdata;
    assign cmd_ready = (fifo_count < DepthCnt);
    assign push      = cmd_valid && cmd_ready;
    assign is_last   = (beat_q == head.len);
    assign pop       = (beat_fire || flush_fire) && is_last;
    assign busy      = (state_q != StIdle) || (fifo_count != '0);
    assign timeout_err = err_q;

    bus_cmd_fifo #(
        .Width(CmdWidth),
        .Depth(FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .push_i (push),
        .wdata_i({cmd_addr, cmd_len}),
        .pop_i  (pop),
        .rdata_o(fifo_rdata),
        .count_o(fifo_count),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Bus-side outputs decoded from state, grant and the write-data handshake
    always_comb begin
        req         = 1'b0;
        bus_valid   = 1'b0;
        bus_addr    = '0;
        bus_data    = '0;
        bus_last    = 1'b0;
        wdata_ready = 1'b0;
        beat_fire   = 1'b0;
        flush_fire  = 1'b0;
        case (state_q)
            StReq: req = 1'b1;
            StXfer: begin
                req       = 1'b1;
                beat_fire = grant && wdata_valid;
                if (beat_fire) begin
                    bus_valid   = 1'b1;
                    wdata_ready = 1'b1;
                    bus_data    = wdata;
                    bus_addr    = head.addr + ADDR_WIDTH'(beat_q);
                    bus_last    = is_last;
                end
            end
            StFlush: begin
                wdata_ready = wdata_valid;
                flush_fire  = wdata_valid;
            end
            default: ;
        endcase
    end

    // FSM, beat counter, grant-timeout counter and sticky error next-state
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        tmo_d   = '0;
        tmo_set = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty || push) state_d = StReq;
            end
            StReq: begin
                if (grant) begin
                    state_d = StXfer;
                end else if (TimeoutEn && (tmo_q == TmoLast)) begin
                    state_d = StFlush;
                    tmo_set = 1'b1;
                end else begin
                    tmo_d = tmo_q + TmoOne;
                end
            end
            StXfer, StFlush: begin
                if (beat_fire || flush_fire) begin
                    beat_d = is_last ? '0 : beat_q + BeatOne;
                    if (is_last) state_d = StGap;
                end
            end
            StGap: begin
                // Go straight back to REQ when work is queued so req drops for only one cycle
                state_d = (!fifo_empty || push) ? StReq : StIdle;
            end
            default: state_d = StIdle;
        endcase
        err_d = tmo_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule
